// File: rtl/peripheral_ctrl_pkg.sv
// Shared definitions for the peripheral port controller: opcode and FSM
// state encodings, the strobe bundle, and small decode helpers.
package peripheral_ctrl_pkg;

   // Requester opcodes as seen on op0/op1.
   typedef enum logic [1:0] {
      OP_NOP       = 2'b00,
      OP_SET_DIR   = 2'b01,
      OP_WRITE_OUT = 2'b10,
      OP_READ_IN   = 2'b11
   } op_t;

   // Controller FSM: one grant cycle, one execute cycle, one acknowledge cycle.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      ACK  = 2'b10
   } state_t;

   // Everything the controller presents to the peripheral during EXEC.
   typedef struct packed {
      logic read_in;
      logic load_out;
      logic load_dir;
      logic bus_oe;
   } strobe_t;

   // Map an opcode onto its peripheral strobes. Only ops that put data on
   // the bus enable the driver, so bus_oe and read_in are mutually exclusive
   // by construction and at most one load/read strobe is ever set.
   function automatic strobe_t decode_op(op_t op);
      strobe_t s;
      s = '0;
      unique case (op)
         OP_SET_DIR:   begin s.load_dir = 1'b1; s.bus_oe = 1'b1; end
         OP_WRITE_OUT: begin s.load_out = 1'b1; s.bus_oe = 1'b1; end
         OP_READ_IN:   s.read_in = 1'b1;
         default:      s = '0;
      endcase
      return s;
   endfunction

   // One-hot acknowledge vector for a requester index.
   function automatic logic [1:0] grant_onehot(logic idx);
      return {idx, ~idx};
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. A lone requester always wins; under
// contention the requester that was not granted last wins. The pointer
// only moves when the caller actually takes the grant (advance).
module rr_arbiter2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant
);

   logic last_q;

   // Pick the winner from the current requests and the last-grant pointer.
   // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      grant = 1'b0;
      unique case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_q;
         default: grant = 1'b0;
      endcase
   end

   // Remember who was granted; reset points at requester 1 so requester 0
   // wins the first contention.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset)
         last_q <= 1'b1;
      else if (advance)
         last_q <= grant;
   end

endmodule

// File: rtl/peripheral_port_controller.sv
// Arbitrates two requesters onto a single peripheral port. A granted
// operation is latched in IDLE, drives the peripheral strobes for exactly
// one EXEC cycle, and is acknowledged with a one-cycle pulse in ACK.
module peripheral_port_controller
   import peripheral_ctrl_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [1:0]   req,
   input  logic [1:0]   op0,
   input  logic [1:0]   op1,
   input  logic [N-1:0] wdata0,
   input  logic [N-1:0] wdata1,
   output logic [1:0]   ack,
   output logic [N-1:0] rdata,
   output logic [N-1:0] bus_out,
   output logic         bus_oe,
   input  logic [N-1:0] bus_in,
   output logic         READ_IN,
   output logic         LOAD_OUT,
   output logic         LOAD_DIR,
   output logic [N-1:0] dir_shadow
);

   state_t         state;
   logic           winner_q;
   op_t            op_q;
   logic [N-1:0]   data_q;

   logic           grant;
   logic           advance;
   op_t            sel_op;
   logic [N-1:0]   sel_data;
   strobe_t        sel_strobe;

   // A grant is taken only from IDLE, which also fixes the three-cycle
   // cadence: nothing arriving during EXEC or ACK can be granted early.
   assign advance = (state == IDLE) && (req != 2'b00);

   rr_arbiter2 u_arbiter (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .advance (advance),
      .grant   (grant)
   );

   // Select the winning requester's opcode and data and pre-decode the
   // strobes so they can be registered straight into EXEC.
   always_comb begin
      sel_op     = grant ? op_t'(op1) : op_t'(op0);
      sel_data   = grant ? wdata1 : wdata0;
      sel_strobe = decode_op(sel_op);
   end

   // Controller FSM with registered outputs. Strobes and bus drive are
   // loaded on the IDLE->EXEC edge and cleared on the EXEC->ACK edge, so
   // they are high for exactly the EXEC cycle. The operation is fully
   // latched at grant time, so later input changes or a dropped req cannot
   // alter or cancel it; only reset aborts it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         winner_q   <= 1'b0;
         op_q       <= OP_NOP;
         data_q     <= '0;
         ack        <= 2'b00;
         READ_IN    <= 1'b0;
         LOAD_OUT   <= 1'b0;
         LOAD_DIR   <= 1'b0;
         bus_oe     <= 1'b0;
         bus_out    <= '0;
         rdata      <= '0;
         dir_shadow <= '0;
      end else begin
         // Pulses fall back to zero unless the current state re-asserts them.
         ack      <= 2'b00;
         READ_IN  <= 1'b0;
         LOAD_OUT <= 1'b0;
         LOAD_DIR <= 1'b0;
         bus_oe   <= 1'b0;
         bus_out  <= '0;

         unique case (state)
            IDLE: begin
               if (advance) begin
                  winner_q <= grant;
                  op_q     <= sel_op;
                  data_q   <= sel_data;
                  READ_IN  <= sel_strobe.read_in;
                  LOAD_OUT <= sel_strobe.load_out;
                  LOAD_DIR <= sel_strobe.load_dir;
                  bus_oe   <= sel_strobe.bus_oe;
                  bus_out  <= sel_strobe.bus_oe ? sel_data : '0;
                  state    <= EXEC;
               end
            end

            EXEC: begin
               // The peripheral has had the whole EXEC cycle to respond, so
               // read data and the direction copy are captured at its end.
               if (op_q == OP_READ_IN)
                  rdata <= bus_in;
               if (op_q == OP_SET_DIR)
                  dir_shadow <= data_q;
               ack   <= grant_onehot(winner_q);
               state <= ACK;
            end

            ACK: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
